// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU instruction fetch slice.
//   fetch_state_t : fetch FSM encoding (IDLE, REQ, VALID, HALT)
//   RESET_VECTOR  : PC value loaded on reset
//   HALT_ADDR     : reaching this PC stops the fetch unit
//   PC_STEP       : sequential instruction stride in bytes
//   word_align()  : clears the byte-offset bits of an address
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_cpu_pc_reg.sv
// Program counter with branch/jump target latch.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   load_en        : target capture allowed (low once halted)
//   pc_load        : a branch/jump target is presented this cycle
//   pc_load_value  : target address (bits [1:0] forced to zero)
//   advance        : instruction handed over; move to next pc
//   pc             : current fetch address
//   pc_next        : value pc takes on advance (used for halt detection)
//   pending        : a captured target is waiting for the next advance
module mips_cpu_pc_reg
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        pc_load,
  input  logic [31:0] pc_load_value,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pending
);

  logic [31:0] target;
  logic        load_now;

  assign load_now = load_en & pc_load;

  // A target presented in the same cycle as the advance overrides any
  // older pending one; otherwise the pending target wins over pc+4.
  // pc+4 wraps naturally in 32 bits.
  always_comb begin
    pc_next = pc + PC_STEP;
    if (load_now) begin
      pc_next = word_align(pc_load_value);
    end else if (pending) begin
      pc_next = target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      target  <= '0;
      pending <= 1'b0;
    end else if (advance) begin
      pc      <= pc_next;
      pending <= 1'b0;
    end else if (load_now) begin
      // Later loads simply overwrite earlier ones: last one wins.
      target  <= word_align(pc_load_value);
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/mips_cpu_instr_fetch.sv
// Instruction fetch unit: owns the PC, reads instructions over an
// Avalon-style bus, holds each word until the instruction register takes
// it, and redirects the PC with MIPS delay-slot semantics. Fetching stops
// for good (until reset) when the PC reaches address 0.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   fetch_en         : control requests fetching (sampled in IDLE/VALID)
//   mem_address      : fetch byte address, always equal to pc
//   mem_read         : registered read strobe
//   mem_waitrequest  : memory stall
//   mem_readdata     : instruction word, valid in the completing cycle
//   instr            : held instruction word
//   instr_valid      : instr is valid
//   instr_ready      : instruction register accepts instr
//   pc_load          : branch/jump target pending
//   pc_load_value    : target address
//   pc               : address of the next or current fetch
//   active           : high until halt
//   dbg_state        : current FSM state
//   dbg_pending      : a branch target is latched
//
// Handshakes: the bus read completes in a cycle with mem_read=1 and
// mem_waitrequest=0; the instruction transfers in a cycle with
// instr_valid=1 and instr_ready=1. instr is stable while instr_valid=1
// and mem_read/mem_address are stable while mem_waitrequest=1.
module mips_cpu_instr_fetch
  import mips_cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_en,
  output logic [31:0]  mem_address,
  output logic         mem_read,
  input  logic         mem_waitrequest,
  input  logic [31:0]  mem_readdata,
  output logic [31:0]  instr,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         pc_load,
  input  logic [31:0]  pc_load_value,
  output logic [31:0]  pc,
  output logic         active,
  output fetch_state_t dbg_state,
  output logic         dbg_pending
);

  fetch_state_t state, state_next;
  logic         handshake;
  logic         read_done;
  logic [31:0]  pc_next;

  assign handshake = (state == VALID) & instr_ready;
  assign read_done = (state == REQ) & ~mem_waitrequest;

  mips_cpu_pc_reg u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .load_en       (state != HALT),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .advance       (handshake),
    .pc            (pc),
    .pc_next       (pc_next),
    .pending       (dbg_pending)
  );

  // pc only changes on a handshake, so the address is stable across REQ.
  assign mem_address = pc;
  assign dbg_state   = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (fetch_en) state_next = REQ;
      REQ:   if (!mem_waitrequest) state_next = VALID;
      VALID: begin
        if (instr_ready) begin
          if (pc_next == HALT_ADDR) state_next = HALT;
          else if (fetch_en)        state_next = REQ;
          else                      state_next = IDLE;
        end
      end
      HALT:  state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are flops decoded from the next state, so they switch cleanly
  // on the clock edge and drop at once on an asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      instr_valid <= 1'b0;
      active      <= 1'b1;
    end else begin
      state       <= state_next;
      mem_read    <= (state_next == REQ);
      instr_valid <= (state_next == VALID);
      active      <= (state_next != HALT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= '0;
    end else if (read_done) begin
      instr <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_mips_cpu_instr_fetch.sv
// Directed bench for mips_cpu_instr_fetch. Inputs change on the falling
// edge; outputs are sampled on the falling edge, away from the rising edge.
module tb_mips_cpu_instr_fetch;
  import mips_cpu_pkg::*;

  logic         clk;
  logic         reset;
  logic         fetch_en;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_waitrequest;
  logic [31:0]  mem_readdata;
  logic [31:0]  instr;
  logic         instr_valid;
  logic         instr_ready;
  logic         pc_load;
  logic [31:0]  pc_load_value;
  logic [31:0]  pc;
  logic         active;
  fetch_state_t dbg_state;
  logic         dbg_pending;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  mips_cpu_instr_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .pc_load         (pc_load),
    .pc_load_value   (pc_load_value),
    .pc              (pc),
    .active          (active),
    .dbg_state       (dbg_state),
    .dbg_pending     (dbg_pending)
  );

  // Memory: one fixed word at the reset vector, elsewhere a word that
  // encodes the low address half so each fetch is identifiable.
  always_comb begin
    if (mem_address == 32'hBFC0_0000) mem_readdata = 32'h2408_0005;
    else                              mem_readdata = {16'hABCD, mem_address[15:0]};
  end

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in REQ and no wait states:
  // completes the read, checks the word, hands it over.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
    check({tag, "_rd"},   {31'b0, mem_read}, 32'd1);
    check({tag, "_addr"}, mem_address, addr);
    step();
    check({tag, "_vld"},  {31'b0, instr_valid}, 32'd1);
    check({tag, "_ins"},  instr, word);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset           = 1'b1;
    fetch_en        = 1'b0;
    mem_waitrequest = 1'b0;
    instr_ready     = 1'b0;
    pc_load         = 1'b0;
    pc_load_value   = '0;
    step();
    step();

    // Reset values
    check("rst_pc",     pc, 32'hBFC0_0000);
    check("rst_addr",   mem_address, 32'hBFC0_0000);
    check("rst_rd",     {31'b0, mem_read}, 32'd0);
    check("rst_instr",  instr, 32'd0);
    check("rst_vld",    {31'b0, instr_valid}, 32'd0);
    check("rst_active", {31'b0, active}, 32'd1);
    check("rst_state",  {30'b0, dbg_state}, {30'b0, IDLE});
    check("rst_pend",   {31'b0, dbg_pending}, 32'd0);

    // Minimum latency: fetch_en sampled at edge 0
    reset    = 1'b0;
    fetch_en = 1'b1;
    step();
    check("lat_rd_c1",   {31'b0, mem_read}, 32'd1);
    check("lat_addr_c1", mem_address, 32'hBFC0_0000);
    check("lat_vld_c1",  {31'b0, instr_valid}, 32'd0);
    step();
    check("lat_vld_c2",  {31'b0, instr_valid}, 32'd1);
    check("lat_ins_c2",  instr, 32'h2408_0005);
    check("lat_rd_c2",   {31'b0, mem_read}, 32'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("hs_pc",       pc, 32'hBFC0_0004);
    check("hs_rd",       {31'b0, mem_read}, 32'd1);

    // Wait states: waitrequest high for 3 REQ cycles
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("ws_rd",   {31'b0, mem_read}, 32'd1);
      check("ws_addr", mem_address, 32'hBFC0_0004);
      check("ws_vld",  {31'b0, instr_valid}, 32'd0);
    end
    step();
    check("ws_rd4",   {31'b0, mem_read}, 32'd1);
    check("ws_addr4", mem_address, 32'hBFC0_0004);
    mem_waitrequest = 1'b0;
    step();
    check("ws_vld_after", {31'b0, instr_valid}, 32'd1);
    check("ws_ins",       instr, 32'hABCD_0004);

    // Consumer stall: instr_ready low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_ins", instr, 32'hABCD_0004);
      check("stall_vld", {31'b0, instr_valid}, 32'd1);
      check("stall_rd",  {31'b0, mem_read}, 32'd0);
      check("stall_pc",  pc, 32'hBFC0_0004);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("stall_pc_adv", pc, 32'hBFC0_0008);

    // Branch at BFC0_0010 with target BFC0_0103 (low bits dropped)
    do_fetch("f08", 32'hBFC0_0008, 32'hABCD_0008);
    do_fetch("f0c", 32'hBFC0_000C, 32'hABCD_000C);
    do_fetch("br",  32'hBFC0_0010, 32'hABCD_0010);
    pc_load       = 1'b1;
    pc_load_value = 32'hBFC0_0103;
    check("ds_addr", mem_address, 32'hBFC0_0014);
    step();
    pc_load = 1'b0;
    check("ds_ins",  instr, 32'hABCD_0014);
    check("ds_pc",   pc, 32'hBFC0_0014);
    check("ds_pend", {31'b0, dbg_pending}, 32'd1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("tgt_pc",   pc, 32'hBFC0_0100);
    check("tgt_pend", {31'b0, dbg_pending}, 32'd0);
    do_fetch("tgt", 32'hBFC0_0100, 32'hABCD_0100);

    // Two loads: the second coincides with the handshake and wins
    pc_load       = 1'b1;
    pc_load_value = 32'h0000_2000;
    step();
    pc_load_value = 32'h0000_3001;
    instr_ready   = 1'b1;
    step();
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    check("last_pc", pc, 32'h0000_3000);
    do_fetch("f3000", 32'h0000_3000, 32'hABCD_3000);

    // Jump to address 0 -> HALT after the delay slot
    pc_load       = 1'b1;
    pc_load_value = 32'h0000_0000;
    step();
    pc_load = 1'b0;
    check("hd_ins", instr, 32'hABCD_3004);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("halt_state",  {30'b0, dbg_state}, {30'b0, HALT});
    check("halt_active", {31'b0, active}, 32'd0);
    check("halt_pc",     pc, 32'd0);
    pc_load       = 1'b1;
    pc_load_value = 32'h0000_0040;
    instr_ready   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_rd",   {31'b0, mem_read}, 32'd0);
      check("halt_vld",  {31'b0, instr_valid}, 32'd0);
      check("halt_act",  {31'b0, active}, 32'd0);
      check("halt_pcs",  pc, 32'd0);
      check("halt_pend", {31'b0, dbg_pending}, 32'd0);
    end
    pc_load     = 1'b0;
    instr_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("unhalt_active", {31'b0, active}, 32'd1);
    check("unhalt_pc",     pc, 32'hBFC0_0000);
    step();

    // Reset in the middle of a stalled read
    reset           = 1'b0;
    fetch_en        = 1'b1;
    mem_waitrequest = 1'b1;
    step();
    check("mr_rd", {31'b0, mem_read}, 32'd1);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("mr_async_rd", {31'b0, mem_read}, 32'd0);
    step();
    reset           = 1'b0;
    fetch_en        = 1'b0;
    mem_waitrequest = 1'b0;
    step();
    check("mr_pc",    pc, 32'hBFC0_0000);
    check("mr_vld",   {31'b0, instr_valid}, 32'd0);
    check("mr_instr", instr, 32'd0);
    check("mr_idle",  {30'b0, dbg_state}, {30'b0, IDLE});
    check("mr_idle_rd", {31'b0, mem_read}, 32'd0);

    // Wrap: target FFFF_FFFF aligns to FFFF_FFFC, +4 wraps to 0 -> HALT
    fetch_en = 1'b1;
    step();
    pc_load       = 1'b1;
    pc_load_value = 32'hFFFF_FFFF;
    step();
    pc_load     = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("wrap_tgt", pc, 32'hFFFF_FFFC);
    do_fetch("wrap", 32'hFFFF_FFFC, 32'hABCD_FFFC);
    check("wrap_pc",    pc, 32'd0);
    check("wrap_halt",  {30'b0, dbg_state}, {30'b0, HALT});
    check("wrap_rd",    {31'b0, mem_read}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
